speed_meter_multi: RTL and testbench
====================================

Name: speed_meter_multi

Overview:
Parametrised multi-channel successor to the single-input 32-bit speed measurement block. Measures the period between qualified edges on each of CHANNELS tacho/encoder inputs, averages 2^AVG_LOG2 periods, and detects stalls via timeout. Sits between the board sensor pins and the motor-control/register layer. Uses one clock domain; inputs are asynchronous.

Parameters:
CHANNELS, 2, number of independent input channels (1..8)
CNT_W, 32, width of the period counter and of each period result
AVG_LOG2, 2, log2 of the number of periods averaged per result (0..4)
TIMEOUT, 1000000, clock cycles without a qualified edge before a channel is declared stalled (< 2^CNT_W)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in  in  CHANNELS  raw sensor inputs, asynchronous to clk
edge_sel  in  2  0=rising, 1=falling, 2=both, 3=treated as rising; common to all channels
period  out  CHANNELS*CNT_W  averaged period in clk cycles per channel (ch n at [n*CNT_W +: CNT_W]); 0 = stalled
valid  out  CHANNELS  one-cycle strobe per channel when its period is updated
stalled  out  CHANNELS  per channel, 1 = no valid measurement or timed out

Behaviour:
- Reset (async): period=0, valid=0, stalled=all 1s, counters/accumulators 0, all channels disarmed. Sync regs cleared.
- Input path per channel: 2-FF synchroniser + 1 history FF; qualified edge event per edge_sel. Pin change -> event asserted 3 clk later.
- Period counter cnt: increments each cycle while armed, saturates at TIMEOUT. On event: sample = cnt, cnt <= 1. Events at cycles t0,t1 give sample = t1-t0.
- Arming: first event after reset, timeout or edge_sel change only arms (cnt<=1), no sample taken.
- Averaging: acc (CNT_W+AVG_LOG2 bits, cannot overflow) sums samples; sample counter counts to 2^AVG_LOG2. On the event completing the set: period <= (acc+sample)>>AVG_LOG2 (truncate), valid=1 next cycle, stalled<=0, acc and sample counter cleared. Channel stays armed; the completing edge is the start of the next period.
- Timeout: armed and no event on the cycle cnt would reach TIMEOUT -> next cycle period<=0, valid=1 (once), stalled<=1, disarm, acc/sample counter cleared. No further valid until re-armed and a full set completes.
- Event and timeout in the same cycle: event wins (sample = TIMEOUT-equivalent cnt, no timeout).
- edge_sel change (registered compare): all channels disarm, acc cleared, period and stalled hold last value; no valid pulse.
- Channels fully independent; simultaneous events on several channels handled in parallel, valid may assert on several bits in the same cycle.
- Reset mid-measurement: immediate clear to reset values; partial averages discarded.
- States per channel: IDLE (disarmed) -> ARMED on event; ARMED -> ARMED on event/valid; ARMED -> IDLE on timeout or edge_sel change.

Decomposition:
- Package: edge_sel encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH), channel state enum (IDLE, ARMED), default CNT_W/TIMEOUT constants.
- One sub-module speed_meter_channel: synchroniser, edge qualifier, counter, accumulator, timeout, state; top instantiates CHANNELS copies via generate and fans out edge_sel change pulse.

Test Plan:
- Ch0 square wave 1000 clk high/1000 low, edge_sel=0, AVG_LOG2=2 -> first valid after 5th rising edge (+3 sync +1), period[0]=2000, stalled[0]=0; valid repeats every 4 edges.
- Same wave, edge_sel=2 -> period[0]=1000, valid every 4 edges (every 4000 cycles).
- Rising periods 1998,2002,2000,2004 -> period[0]=8004>>2=2001; periods 2000,2000,2000,2001 -> 2000 (truncation).
- TIMEOUT=10000, input stops after an edge -> exactly one valid with period[0]=0, stalled[0]=1 10000 cycles later; restart toggling -> stalled clears only at next completed average of 5 edges.
- Ch0 period 2000, ch1 period 500 with coincident edges -> period[0]=2000, period[1]=500, coincident valid bits both seen, no cross-talk.
- Assert reset between edges mid-average -> outputs at reset values asynchronously; after release first edge only arms, first result after 5 edges; edge_sel change mid-average -> no valid, partial set discarded.

Source files
------------

// File: rtl/speed_meter_multi_pkg.sv
// ---------------------------------------------------------------------------
// speed_meter_multi_pkg
// Shared definitions for the multi-channel speed meter:
//   - edge_sel encodings (EDGE_RISE, EDGE_FALL, EDGE_BOTH; code 3 acts as rise)
//   - per-channel state enum (IDLE = disarmed, ARMED = measuring)
//   - default counter width and timeout
//   - edge_qualify(): turns a synchronised sample plus its history bit into
//     a qualified edge event for the selected edge mode
// ---------------------------------------------------------------------------
package speed_meter_multi_pkg;

    localparam logic [1:0] EDGE_RISE = 2'd0;
    localparam logic [1:0] EDGE_FALL = 2'd1;
    localparam logic [1:0] EDGE_BOTH = 2'd2;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 1000000;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chan_state_e;

    // Code 3 is unassigned and deliberately falls into the rising default.
    function automatic logic edge_qualify(input logic [1:0] sel,
                                          input logic       cur,
                                          input logic       prev);
        case (sel)
            EDGE_FALL: return ~cur & prev;
            EDGE_BOTH: return cur ^ prev;
            default:   return cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/speed_meter_channel.sv
// ---------------------------------------------------------------------------
// speed_meter_channel
// One measurement channel: 2-FF synchroniser + history FF, edge qualifier,
// saturating period counter, 2^AVG_LOG2 sample accumulator, stall timeout
// and the IDLE/ARMED state machine.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   in_i           raw sensor pin (asynchronous)
//   edge_sel_i     edge mode (already registered by the top)
//   sel_change_i   one-cycle pulse: edge mode changed, disarm and discard
//   period_o       averaged period in clk cycles, 0 after a stall
//   valid_o        one-cycle strobe when period_o was updated
//   stalled_o      1 = no valid measurement yet or timed out
//   armed_o        debug view of the state machine (1 = ARMED)
//
// Output protocol: valid_o is a pure strobe with no back-pressure; a consumer
// must capture period_o/stalled_o in the cycle valid_o is high. period_o and
// stalled_o hold their value between strobes.
// ---------------------------------------------------------------------------
module speed_meter_channel
    import speed_meter_multi_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_i,
    input  logic [1:0]       edge_sel_i,
    input  logic             sel_change_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             stalled_o,
    output logic             armed_o
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SC_W  = AVG_LOG2 + 1;
    localparam logic [SC_W-1:0]  SC_LAST = SC_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    // Input path
    logic sync1_q, sync2_q, hist_q, evt_q;

    // Measurement state
    chan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [SC_W-1:0]  sc_q;
    logic [CNT_W-1:0] period_q;
    logic             valid_q;
    logic             stalled_q;

    logic [ACC_W-1:0] sum_d;
    logic [CNT_W-1:0] cnt_inc_d;

    // The qualified edge is registered so a pin change reaches the state
    // machine three clocks later; the result strobe follows one clock after.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            evt_q   <= edge_qualify(edge_sel_i, sync2_q, hist_q);
        end
    end

    // Accumulator is CNT_W+AVG_LOG2 wide, so the full set cannot overflow.
    assign sum_d     = acc_q + ACC_W'(cnt_q);
    assign cnt_inc_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sc_q      <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            if (sel_change_i) begin
                // Mode change: drop the partial set, keep the last result.
                state_q <= IDLE;
                cnt_q   <= '0;
                acc_q   <= '0;
                sc_q    <= '0;
            end else if (state_q == IDLE) begin
                // First edge only opens a period; nothing to sample yet.
                if (evt_q) begin
                    state_q <= ARMED;
                    cnt_q   <= CNT_W'(1);
                end
            end else begin
                if (evt_q) begin
                    // An edge on the timeout cycle wins over the timeout.
                    cnt_q <= CNT_W'(1);
                    if (sc_q == SC_LAST) begin
                        period_q  <= sum_d[ACC_W-1:AVG_LOG2];
                        valid_q   <= 1'b1;
                        stalled_q <= 1'b0;
                        acc_q     <= '0;
                        sc_q      <= '0;
                    end else begin
                        acc_q <= sum_d;
                        sc_q  <= sc_q + SC_W'(1);
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Counter would reach TIMEOUT: report the stall once.
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    acc_q     <= '0;
                    sc_q      <= '0;
                    period_q  <= '0;
                    valid_q   <= 1'b1;
                    stalled_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc_d;
                end
            end
        end
    end

    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign stalled_o = stalled_q;
    assign armed_o   = (state_q == ARMED);

endmodule

// File: rtl/speed_meter_multi.sv
// ---------------------------------------------------------------------------
// speed_meter_multi
// Multi-channel tacho/encoder period meter. Each of CHANNELS inputs gets an
// independent speed_meter_channel; the edge mode is shared and registered
// here so a change can be broadcast to every channel as a one-cycle pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   in         CHANNELS raw sensor inputs (asynchronous)
//   edge_sel   0 rise, 1 fall, 2 both, 3 rise; common to all channels
//   period     CHANNELS*CNT_W averaged periods, channel n at [n*CNT_W +: CNT_W]
//   valid      per-channel one-cycle update strobe
//   stalled    per-channel stall/no-measurement flag
//   state_dbg  per-channel state machine view (1 = ARMED)
// ---------------------------------------------------------------------------
module speed_meter_multi
    import speed_meter_multi_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in,
    input  logic [1:0]                edge_sel,
    output logic [CHANNELS*CNT_W-1:0] period,
    output logic [CHANNELS-1:0]       valid,
    output logic [CHANNELS-1:0]       stalled,
    output logic [CHANNELS-1:0]       state_dbg
);

    logic [1:0] edge_sel_q;
    logic       sel_change_d;

    // Channels qualify edges with the registered mode; the cycle in which
    // the raw mode differs from it is the broadcast disarm pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_sel_q <= EDGE_RISE;
        end else begin
            edge_sel_q <= edge_sel;
        end
    end

    assign sel_change_d = (edge_sel != edge_sel_q);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        speed_meter_channel #(
            .CNT_W    (CNT_W),
            .AVG_LOG2 (AVG_LOG2),
            .TIMEOUT  (TIMEOUT)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .in_i         (in[g]),
            .edge_sel_i   (edge_sel_q),
            .sel_change_i (sel_change_d),
            .period_o     (period[g*CNT_W +: CNT_W]),
            .valid_o      (valid[g]),
            .stalled_o    (stalled[g]),
            .armed_o      (state_dbg[g])
        );
    end

endmodule

// File: tb/tb_speed_meter_multi.sv
// Directed bench for speed_meter_multi: square waves and explicit pulse
// trains with hand-computed periods, latencies and valid counts.
module tb_speed_meter_multi;

    localparam int CH       = 2;
    localparam int CNT_W    = 32;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 10000;
    localparam int LAT      = 4;   // pin change -> valid strobe, in clocks

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CH-1:0]         in;
    logic [1:0]            edge_sel;
    logic [CH*CNT_W-1:0]   period;
    logic [CH-1:0]         valid;
    logic [CH-1:0]         stalled;
    logic [CH-1:0]         state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int half     [CH];
    int ph       [CH];
    int last_tog [CH];
    int vcount   [CH];
    int vcyc     [CH];
    logic [CNT_W-1:0] vper [CH];
    int coinc;
    int first_v;

    speed_meter_multi #(
        .CHANNELS (CH),
        .CNT_W    (CNT_W),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .edge_sel  (edge_sel),
        .period    (period),
        .valid     (valid),
        .stalled   (stalled),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- valid monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                vcount[c] = 0;
                vcyc[c]   = 0;
                vper[c]   = '0;
            end
            coinc = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (valid[c]) begin
                    vcount[c]++;
                    vcyc[c] = cyc;
                    vper[c] = period[c*CNT_W +: CNT_W];
                end
            end
            if (&valid) coinc++;
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Square waves: channel c toggles every half[c] cycles (0 = hold).
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (half[c] != 0) begin
                    if (ph[c] == 0) begin
                        in[c] = ~in[c];
                        last_tog[c] = cyc;
                    end
                    ph[c] = (ph[c] + 1) % half[c];
                end
            end
            tick();
        end
    endtask

    // One rising edge on ch0, then `gap` cycles until the next call.
    task automatic gap_rise(input int gap);
        in[0] = 1'b1;
        last_tog[0] = cyc;
        repeat (10) tick();
        in[0] = 1'b0;
        repeat (gap - 10) tick();
    endtask

    task automatic do_reset(input logic [1:0] sel);
        reset = 1'b1;
        in = '0;
        edge_sel = sel;
        for (int c = 0; c < CH; c++) begin
            half[c] = 0;
            ph[c]   = 0;
        end
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        in = '0;
        edge_sel = 2'd0;
        repeat (3) tick();
        n_vec++; if (period !== '0) begin n_err++; $display("FAIL reset_period: got %0h expected 0", period); end
        n_vec++; if (valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b expected 00", valid); end
        n_vec++; if (stalled !== 2'b11) begin n_err++; $display("FAIL reset_stalled: got %b expected 11", stalled); end
        n_vec++; if (state_dbg !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b expected 00", state_dbg); end
        reset = 1'b0;
        run(20);
        n_vec++; if (stalled !== 2'b11) begin n_err++; $display("FAIL idle_stalled: got %b expected 11", stalled); end
        n_vec++; if (vcount[0] + vcount[1] !== 0) begin n_err++; $display("FAIL idle_valid: got %0d strobes expected 0", vcount[0] + vcount[1]); end
    endtask

    task automatic test_rising();
        do_reset(2'd0);
        half[0] = 1000;
        run(8010);   // rising edges at 0,2000,..,8000 -> one result
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL rise_count: got %0d expected 1", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd2000) begin n_err++; $display("FAIL rise_period: got %0d expected 2000", vper[0]); end
        n_vec++; if (stalled[0] !== 1'b0) begin n_err++; $display("FAIL rise_stalled: got %b expected 0", stalled[0]); end
        n_vec++; if (vcyc[0] - last_tog[0] !== LAT) begin n_err++; $display("FAIL rise_latency: got %0d expected %0d", vcyc[0] - last_tog[0], LAT); end
        n_vec++; if (state_dbg[0] !== 1'b1) begin n_err++; $display("FAIL rise_armed: got %b expected 1", state_dbg[0]); end
        first_v = vcyc[0];
        run(8000);   // four more rising edges
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL rise_repeat_count: got %0d expected 2", vcount[0]); end
        n_vec++; if (vcyc[0] - first_v !== 8000) begin n_err++; $display("FAIL rise_repeat_spacing: got %0d expected 8000", vcyc[0] - first_v); end
        n_vec++; if (vper[0] !== 32'd2000) begin n_err++; $display("FAIL rise_repeat_period: got %0d expected 2000", vper[0]); end
        n_vec++; if (vcount[1] !== 0) begin n_err++; $display("FAIL rise_ch1_quiet: got %0d expected 0", vcount[1]); end
    endtask

    task automatic test_both_edges();
        do_reset(2'd2);
        half[0] = 1000;
        run(4010);   // edges at 0,1000,..,4000
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL both_count: got %0d expected 1", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd1000) begin n_err++; $display("FAIL both_period: got %0d expected 1000", vper[0]); end
        first_v = vcyc[0];
        run(4000);
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL both_repeat_count: got %0d expected 2", vcount[0]); end
        n_vec++; if (vcyc[0] - first_v !== 4000) begin n_err++; $display("FAIL both_repeat_spacing: got %0d expected 4000", vcyc[0] - first_v); end
    endtask

    task automatic test_edge_modes();
        do_reset(2'd1);
        half[0] = 50;
        run(460);    // falling edges at 50,150,..,450
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL fall_count: got %0d expected 1", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd100) begin n_err++; $display("FAIL fall_period: got %0d expected 100", vper[0]); end
        n_vec++; if (vcyc[0] - last_tog[0] !== LAT) begin n_err++; $display("FAIL fall_latency: got %0d expected %0d", vcyc[0] - last_tog[0], LAT); end
        do_reset(2'd3);
        half[0] = 50;
        run(410);    // code 3 counts rising edges at 0,100,..,400
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL sel3_count: got %0d expected 1", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd100) begin n_err++; $display("FAIL sel3_period: got %0d expected 100", vper[0]); end
        n_vec++; if (vcyc[0] - last_tog[0] !== LAT) begin n_err++; $display("FAIL sel3_latency: got %0d expected %0d", vcyc[0] - last_tog[0], LAT); end
    endtask

    task automatic test_truncation();
        int gaps [9] = '{198, 202, 200, 204, 200, 200, 200, 201, 50};
        do_reset(2'd0);
        for (int i = 0; i < 9; i++) begin
            gap_rise(gaps[i]);
            if (i == 4) begin
                // 198+202+200+204 = 804, /4 = 201
                n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL avg1_count: got %0d expected 1", vcount[0]); end
                n_vec++; if (vper[0] !== 32'd201) begin n_err++; $display("FAIL avg1_period: got %0d expected 201", vper[0]); end
            end
        end
        // 200+200+200+201 = 801, /4 truncates to 200
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL avg2_count: got %0d expected 2", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd200) begin n_err++; $display("FAIL avg2_period: got %0d expected 200", vper[0]); end
    endtask

    task automatic test_timeout();
        do_reset(2'd0);
        half[0] = 100;
        run(810);    // rising 0..800 -> period 200
        n_vec++; if (vper[0] !== 32'd200) begin n_err++; $display("FAIL to_pre_period: got %0d expected 200", vper[0]); end
        half[0] = 0; // input freezes high after the rising edge at 800
        run(TIMEOUT + 100);
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL to_count: got %0d expected 2", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd0) begin n_err++; $display("FAIL to_period: got %0d expected 0", vper[0]); end
        n_vec++; if (stalled[0] !== 1'b1) begin n_err++; $display("FAIL to_stalled: got %b expected 1", stalled[0]); end
        n_vec++; if (vcyc[0] - last_tog[0] !== TIMEOUT + 3) begin n_err++; $display("FAIL to_timing: got %0d expected %0d", vcyc[0] - last_tog[0], TIMEOUT + 3); end
        n_vec++; if (state_dbg[0] !== 1'b0) begin n_err++; $display("FAIL to_disarmed: got %b expected 0", state_dbg[0]); end
        run(2000);
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL to_single_strobe: got %0d expected 2", vcount[0]); end
        half[0] = 100;
        ph[0] = 0;
        run(800);    // falls at 0, rises at 100,300,500,700
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL restart_early: got %0d expected 2", vcount[0]); end
        n_vec++; if (stalled[0] !== 1'b1) begin n_err++; $display("FAIL restart_still_stalled: got %b expected 1", stalled[0]); end
        n_vec++; if (state_dbg[0] !== 1'b1) begin n_err++; $display("FAIL restart_armed: got %b expected 1", state_dbg[0]); end
        run(200);    // fifth rising edge at 900
        n_vec++; if (vcount[0] !== 3) begin n_err++; $display("FAIL restart_count: got %0d expected 3", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd200) begin n_err++; $display("FAIL restart_period: got %0d expected 200", vper[0]); end
        n_vec++; if (stalled[0] !== 1'b0) begin n_err++; $display("FAIL restart_stalled: got %b expected 0", stalled[0]); end
    endtask

    task automatic test_two_channels();
        do_reset(2'd0);
        half[0] = 1000;
        half[1] = 250;
        run(8010);
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL two_ch0_count: got %0d expected 1", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd2000) begin n_err++; $display("FAIL two_ch0_period: got %0d expected 2000", vper[0]); end
        n_vec++; if (vcount[1] !== 4) begin n_err++; $display("FAIL two_ch1_count: got %0d expected 4", vcount[1]); end
        n_vec++; if (vper[1] !== 32'd500) begin n_err++; $display("FAIL two_ch1_period: got %0d expected 500", vper[1]); end
        n_vec++; if (coinc !== 1) begin n_err++; $display("FAIL two_coincident: got %0d expected 1", coinc); end
        n_vec++; if (stalled !== 2'b00) begin n_err++; $display("FAIL two_stalled: got %b expected 00", stalled); end
    endtask

    task automatic test_reset_mid();
        do_reset(2'd0);
        half[0] = 100;
        run(810);    // first result, period 200
        run(450);    // rising 1000,1200: partial set in progress
        #1;
        reset = 1'b1;
        #1;
        n_vec++; if (period[CNT_W-1:0] !== '0) begin n_err++; $display("FAIL rmid_period: got %0d expected 0", period[CNT_W-1:0]); end
        n_vec++; if (stalled !== 2'b11) begin n_err++; $display("FAIL rmid_stalled: got %b expected 11", stalled); end
        n_vec++; if (state_dbg !== 2'b00) begin n_err++; $display("FAIL rmid_state: got %b expected 00", state_dbg); end
        in = '0;
        half[0] = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        half[0] = 100;
        ph[0] = 0;
        run(700);    // rising 0,200,400,600: only arming + 3 samples
        n_vec++; if (vcount[0] !== 0) begin n_err++; $display("FAIL rmid_early: got %0d expected 0", vcount[0]); end
        n_vec++; if (stalled[0] !== 1'b1) begin n_err++; $display("FAIL rmid_early_stalled: got %b expected 1", stalled[0]); end
        run(110);    // rising 800 completes the set
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL rmid_count: got %0d expected 1", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd200) begin n_err++; $display("FAIL rmid_result: got %0d expected 200", vper[0]); end
        // Two samples into the next set, then switch to both edges.
        run(410);
        edge_sel = 2'd2;
        run(50);
        n_vec++; if (vcount[0] !== 1) begin n_err++; $display("FAIL sel_no_strobe: got %0d expected 1", vcount[0]); end
        n_vec++; if (state_dbg[0] !== 1'b0) begin n_err++; $display("FAIL sel_disarm: got %b expected 0", state_dbg[0]); end
        n_vec++; if (period[CNT_W-1:0] !== 32'd200) begin n_err++; $display("FAIL sel_hold_period: got %0d expected 200", period[CNT_W-1:0]); end
        n_vec++; if (stalled[0] !== 1'b0) begin n_err++; $display("FAIL sel_hold_stalled: got %b expected 0", stalled[0]); end
        run(450);    // edges every 100: arm + 4 samples
        n_vec++; if (vcount[0] !== 2) begin n_err++; $display("FAIL sel_new_count: got %0d expected 2", vcount[0]); end
        n_vec++; if (vper[0] !== 32'd100) begin n_err++; $display("FAIL sel_new_period: got %0d expected 100", vper[0]); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        in = '0;
        edge_sel = 2'd0;
        test_reset();
        test_rising();
        test_both_edges();
        test_edge_modes();
        test_truncation();
        test_timeout();
        test_two_channels();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
